// File: rtl/calc_core.sv
// Four-function decimal calculator core fed by keypad event pulses.
// It holds the operand being typed or the last result for the display driver.
module calc_core #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_num,
    input  logic             is_op,
    input  logic             is_eq,
    input  logic [3:0]       num_val,
    input  logic [1:0]       op_val,
    output logic [WIDTH-1:0] disp_val,
    output logic             disp_neg,
    output logic             err,
    output logic             busy,
    output logic             res_valid
);

    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int ITER_W = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_A, S_OP, S_B, S_CALC, S_DIV, S_RES, S_ERR
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    res;
    logic                res_neg;
    logic                fresh;
    logic [1:0]          op;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    quo;
    logic [ITER_W-1:0]   iter;

    // x*10 + d, wide enough that overflow past WIDTH bits shows in the top nibble
    function automatic logic [WIDTH+3:0] mac10(input logic [WIDTH-1:0] x,
                                               input logic [3:0]       d);
        return ({4'b0000, x} << 3) + ({4'b0000, x} << 1) + {{WIDTH{1'b0}}, d};
    endfunction

    // One restoring-division iteration; returns {remainder, quotient}
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic           take;
        sh   = {r, q[WIDTH-1]};
        take = (sh >= {1'b0, d});
        if (take) sh = sh - {1'b0, d};
        return {sh[WIDTH-1:0], q[WIDTH-2:0], take};
    endfunction

    logic               ev_eq;
    logic               ev_op;
    logic               ev_num;
    logic [WIDTH-1:0]   digit;
    logic [WIDTH+3:0]   a_next;
    logic [WIDTH+3:0]   b_next;
    logic               room;
    logic               a_fits;
    logic               b_fits;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] step;

    // Only the highest-priority pulse of a cycle counts; codes 10..15 are not digits
    assign ev_eq  = is_eq;
    assign ev_op  = is_op & ~is_eq;
    assign ev_num = is_num & ~is_op & ~is_eq & (num_val <= 4'd9);

    assign digit  = {{(WIDTH-4){1'b0}}, num_val};
    assign a_next = mac10(a, num_val);
    assign b_next = mac10(b, num_val);
    assign room   = (cnt != CNT_W'(MAX_DIGITS));
    assign a_fits = (a_next[WIDTH+3:WIDTH] == 4'd0);
    assign b_fits = (b_next[WIDTH+3:WIDTH] == 4'd0);
    assign sum    = {1'b0, a} + {1'b0, b};
    assign prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign step   = div_step(rem, quo, b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_A;
            a         <= '0;
            b         <= '0;
            res       <= '0;
            res_neg   <= 1'b0;
            fresh     <= 1'b0;
            op        <= OP_ADD;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            disp_val  <= '0;
            disp_neg  <= 1'b0;
            err       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            // Display stage: follows the state one clock behind
            fresh     <= 1'b0;
            res_valid <= fresh;
            case (state)
                S_A, S_OP: begin
                    disp_val <= a;
                    disp_neg <= 1'b0;
                    err      <= 1'b0;
                end
                S_B: begin
                    disp_val <= b;
                    disp_neg <= 1'b0;
                    err      <= 1'b0;
                end
                S_RES: begin
                    disp_val <= res;
                    disp_neg <= res_neg;
                    err      <= 1'b0;
                end
                S_ERR: begin
                    disp_val <= '0;
                    disp_neg <= 1'b0;
                    err      <= 1'b1;
                end
                default: ;
            endcase

            // Key handling and arithmetic
            case (state)
                S_A: begin
                    if (ev_eq) begin
                        res     <= a;
                        res_neg <= 1'b0;
                        fresh   <= 1'b1;
                        state   <= S_RES;
                    end else if (ev_op) begin
                        op    <= op_val;
                        state <= S_OP;
                    end else if (ev_num && room && a_fits) begin
                        a   <= a_next[WIDTH-1:0];
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_OP: begin
                    if (ev_op) begin
                        op <= op_val;
                    end else if (ev_num) begin
                        b     <= digit;
                        cnt   <= CNT_W'(1);
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (ev_eq) begin
                        state <= S_CALC;
                    end else if (ev_num && room && b_fits) begin
                        b   <= b_next[WIDTH-1:0];
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CALC: begin
                    case (op)
                        OP_ADD: begin
                            if (sum[WIDTH]) begin
                                state <= S_ERR;
                            end else begin
                                res     <= sum[WIDTH-1:0];
                                res_neg <= 1'b0;
                                fresh   <= 1'b1;
                                state   <= S_RES;
                            end
                        end
                        OP_SUB: begin
                            res     <= (a >= b) ? a - b : b - a;
                            res_neg <= (a < b);
                            fresh   <= 1'b1;
                            state   <= S_RES;
                        end
                        OP_MUL: begin
                            if (prod[2*WIDTH-1:WIDTH] != '0) begin
                                state <= S_ERR;
                            end else begin
                                res     <= prod[WIDTH-1:0];
                                res_neg <= 1'b0;
                                fresh   <= 1'b1;
                                state   <= S_RES;
                            end
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                state <= S_ERR;
                            end else begin
                                rem   <= '0;
                                quo   <= a;
                                iter  <= ITER_W'(WIDTH);
                                busy  <= 1'b1;
                                state <= S_DIV;
                            end
                        end
                        default: state <= S_ERR;
                    endcase
                end
                S_DIV: begin
                    rem  <= step[2*WIDTH-1:WIDTH];
                    quo  <= step[WIDTH-1:0];
                    iter <= iter - ITER_W'(1);
                    if (iter == ITER_W'(1)) begin
                        res     <= step[WIDTH-1:0];
                        res_neg <= 1'b0;
                        fresh   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_RES;
                    end
                end
                S_RES: begin
                    // Chaining continues from the magnitude; the sign is dropped
                    if (ev_op) begin
                        a     <= res;
                        op    <= op_val;
                        state <= S_OP;
                    end else if (ev_num) begin
                        a     <= digit;
                        cnt   <= CNT_W'(1);
                        state <= S_A;
                    end
                end
                S_ERR: begin
                    if (ev_num) begin
                        a     <= digit;
                        cnt   <= CNT_W'(1);
                        state <= S_A;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

endmodule
